// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal receive path: packet header layout,
// destination-match helper and the receive FSM state type.
package mesh_pkg;

  localparam int PKT_W    = 32;
  localparam int NXT_W    = 8;
  localparam int ROW_W    = 4;
  localparam int COL_W    = 4;
  localparam int HDR_W    = NXT_W + ROW_W + COL_W + 1;
  localparam int PAY_W    = PKT_W - HDR_W;

  // Header field positions, counted down from the packet MSB
  localparam int NXT_OFS  = 1;
  localparam int ROW_OFS  = 9;
  localparam int COL_OFS  = 13;
  localparam int MODE_OFS = 17;

  typedef struct packed {
    logic [NXT_W-1:0] nxt_jmp;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
    logic [PAY_W-1:0] payload;
  } mesh_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE
  } rx_state_e;

  function automatic logic pkt_dest_match(input mesh_pkt_t pkt,
                                          input logic [ROW_W-1:0] row,
                                          input logic [COL_W-1:0] col);
    return (pkt.row == row) && (pkt.col == col);
  endfunction

endpackage

// File: rtl/mesh_rx_fifo.sv
// First-word fall-through FIFO for received packets; a read and a write may
// share a cycle even when full, since the read frees the slot first.
module mesh_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra bit so full and empty stay distinguishable
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mesh_term_rx.sv
// Receive endpoint of one mesh terminal: pops packets from the mesh, checks the
// destination, buffers locally and counts. MESH_RX_DROP_MISROUTE_EN drops misroutes.
module mesh_term_rx
  import mesh_pkg::*;
#(
  parameter int PAKG_SIZE = 32,
  parameter int RX_DEPTH  = 8,
  parameter int MY_ROW    = 0,
  parameter int MY_COL    = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pndng,
  input  logic [PAKG_SIZE-1:0] data_out,
  output logic                 pop,
  output logic                 rx_valid,
  output logic [PAKG_SIZE-1:0] rx_data,
  input  logic                 rx_ready,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     misroute_cnt,
  output logic                 err_misroute,
  input  logic                 clr_stats
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_e   state;
  rx_state_e   state_nxt;
  mesh_pkt_t   hdr;
  logic        dest_ok;
  logic        capture;
  logic        fifo_wr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        room;
  logic [AW:0] fifo_count;
  logic [AW:0] occ_incl;

  always_comb begin
    hdr         = '0;
    hdr.nxt_jmp = data_out[PAKG_SIZE-NXT_OFS -: NXT_W];
    hdr.row     = data_out[PAKG_SIZE-ROW_OFS -: ROW_W];
    hdr.col     = data_out[PAKG_SIZE-COL_OFS -: COL_W];
    hdr.mode    = data_out[PAKG_SIZE-MODE_OFS];
  end

  assign dest_ok = pkt_dest_match(hdr, ROW_W'(MY_ROW), COL_W'(MY_COL));
  assign capture = (state == POP);

`ifdef MESH_RX_DROP_MISROUTE_EN
  assign fifo_wr = capture && dest_ok;
`else
  assign fifo_wr = capture;
`endif

  // Room is judged on occupancy plus any write landing this edge
  assign occ_incl = fifo_count + (AW+1)'(fifo_wr);
  assign room     = !fifo_full && (occ_incl < (AW+1)'(RX_DEPTH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // SETTLE lets the mesh refresh pndng/data_out after a pop before we look again
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if (pndng && room) state_nxt = POP;
      POP: begin
        pop       = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt      <= '0;
      misroute_cnt <= '0;
      err_misroute <= 1'b0;
    end else if (clr_stats) begin
      pkt_cnt      <= '0;
      misroute_cnt <= '0;
      err_misroute <= 1'b0;
    end else if (capture) begin
      if (pkt_cnt != CNT_MAX) pkt_cnt <= pkt_cnt + 1'b1;
      if (!dest_ok) begin
        if (misroute_cnt != CNT_MAX) misroute_cnt <= misroute_cnt + 1'b1;
        err_misroute <= 1'b1;
      end
    end
  end

  mesh_rx_fifo #(
    .WIDTH (PAKG_SIZE),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (fifo_wr),
    .wr_data (data_out),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Bench for mesh_term_rx: a queue-based mesh source, a queue scoreboard for the
// local side, directed tables/sequences and a randomized phase.
module tb_mesh_term_rx;

  localparam int PW    = 32;
  localparam int DEPTH = 8;
  localparam int ROW   = 3;
  localparam int COL   = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef MESH_RX_DROP_MISROUTE_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          pndng;
  logic [PW-1:0] data_out;
  logic          pop;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          rx_ready;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] misroute_cnt;
  logic          err_misroute;
  logic          clr_stats;

  int compared   = 0;
  int mismatched = 0;

  logic [PW-1:0] src_q[$];
  logic [PW-1:0] exp_q[$];
  int m_pkt = 0;
  int m_mis = 0;
  bit m_err = 1'b0;
  int pop_total   = 0;
  int deliv_total = 0;
  bit mesh_en     = 1'b1;

  typedef struct {
    logic [PW-1:0] pkt;
    bit            mis;
  } vec_t;

  mesh_term_rx #(
    .PAKG_SIZE (PW),
    .RX_DEPTH  (DEPTH),
    .MY_ROW    (ROW),
    .MY_COL    (COL),
    .CNT_W     (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pndng        (pndng),
    .data_out     (data_out),
    .pop          (pop),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .pkt_cnt      (pkt_cnt),
    .misroute_cnt (misroute_cnt),
    .err_misroute (err_misroute),
    .clr_stats    (clr_stats)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_misroute(input logic [PW-1:0] p);
    logic [3:0] r;
    logic [3:0] c;
    r = p[23:20];
    c = p[19:16];
    return (r != 4'(ROW)) || (c != 4'(COL));
  endfunction

  function automatic logic [PW-1:0] rand_pkt(input bit force_match);
    logic [PW-1:0] p;
    p = $urandom;
    if (force_match || $urandom_range(0, 1) == 1) begin
      p[23:20] = 4'(ROW);
      p[19:16] = 4'(COL);
    end
    return p;
  endfunction

  task automatic apply_stimulus(input logic [PW-1:0] p);
    src_q.push_back(p);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    while (pop !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check_output("wait_pop_timeout", pop, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    mesh_en   = 1'b1;
    rx_ready  = 1'b1;
    clr_stats = 1'b0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check_output("drain_src_empty", src_q.size(), 0);
    check_output("drain_fifo_empty", exp_q.size(), 0);
  endtask

  // Mesh source and scoreboard: observe mid-cycle, then update the mesh just after the edge
  initial begin
    bit            p;
    bit            prev_pop;
    logic [PW-1:0] head;
    prev_pop = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        check_output("rst_pop", pop, 0);
        check_output("rst_rx_valid", rx_valid, 0);
        check_output("rst_rx_data", rx_data, 0);
        check_output("rst_pkt_cnt", pkt_cnt, 0);
        check_output("rst_misroute_cnt", misroute_cnt, 0);
        check_output("rst_err", err_misroute, 0);
        exp_q.delete();
        m_pkt    = 0;
        m_mis    = 0;
        m_err    = 1'b0;
        prev_pop = 1'b0;
      end else begin
        check_output("rx_valid", rx_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check_output("rx_data", rx_data, exp_q[0]);
        check_output("pkt_cnt", pkt_cnt, m_pkt);
        check_output("misroute_cnt", misroute_cnt, m_mis);
        check_output("err_misroute", err_misroute, m_err);
        if (pop) begin
          check_output("pop_single_cycle", prev_pop, 0);
          check_output("pop_needs_room", exp_q.size() < DEPTH, 1);
          check_output("pop_needs_pndng", pndng, 1);
        end
        if (exp_q.size() != 0 && rx_ready) begin
          void'(exp_q.pop_front());
          deliv_total++;
        end
        if (pop && src_q.size() != 0) begin
          head = src_q[0];
          pop_total++;
          if (!is_misroute(head) || !DROP) exp_q.push_back(head);
          if (!clr_stats) begin
            if (m_pkt < CMAX) m_pkt++;
            if (is_misroute(head)) begin
              if (m_mis < CMAX) m_mis++;
              m_err = 1'b1;
            end
          end
        end
        if (clr_stats) begin
          m_pkt = 0;
          m_mis = 0;
          m_err = 1'b0;
        end
        prev_pop = pop;
      end
      p = pop && !rst_i;
      @(posedge clk_i);
      #1;
      if (p && src_q.size() != 0) void'(src_q.pop_front());
      pndng    = (src_q.size() != 0) && ((pndng && !p) || mesh_en);
      data_out = (src_q.size() != 0) ? src_q[0] : '0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   base;
    int   dbase;
    bit   deliver;

    vecs[0] = '{32'h0032_1234, 1'b0};
    vecs[1] = '{32'h0035_1234, 1'b1};
    vecs[2] = '{32'h0042_1234, 1'b1};
    vecs[3] = '{32'hFF32_FFFF, 1'b0};
    vecs[4] = '{32'h0000_0000, 1'b1};
    vecs[5] = '{32'hAB3A_8001, 1'b1};
    vecs[6] = '{32'h1232_0000, 1'b0};

    rst_i     = 1'b1;
    pndng     = 1'b0;
    data_out  = '0;
    rx_ready  = 1'b0;
    clr_stats = 1'b0;
    tick(3);
    rst_i = 1'b0;
    tick(2);

    // Single packet: pop for exactly one cycle, rx_valid in the third pndng cycle
    base = pop_total;
    apply_stimulus(32'h0032_1234);
    tick(1);
    check_output("lat_c1_pndng", pndng, 1);
    check_output("lat_c1_pop", pop, 0);
    check_output("lat_c1_valid", rx_valid, 0);
    tick(1);
    check_output("lat_c2_pop", pop, 1);
    check_output("lat_c2_valid", rx_valid, 0);
    tick(1);
    check_output("lat_c3_pop", pop, 0);
    check_output("lat_c3_valid", rx_valid, 1);
    check_output("lat_rx_data", rx_data, 32'h0032_1234);
    check_output("lat_pkt_cnt", pkt_cnt, 1);
    check_output("lat_misroute_cnt", misroute_cnt, 0);
    tick(5);
    check_output("lat_pop_count", pop_total - base, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);

    // Destination table: counters, flag and delivery per packet
    for (int i = 0; i < 7; i++) begin
      clr_stats = 1'b1;
      tick(1);
      clr_stats = 1'b0;
      base = pop_total;
      apply_stimulus(vecs[i].pkt);
      for (int n = 0; n < 20 && pop_total == base; n++) tick(1);
      tick(1);
      deliver = !vecs[i].mis || !DROP;
      check_output("tbl_misroute_cnt", misroute_cnt, vecs[i].mis);
      check_output("tbl_err", err_misroute, vecs[i].mis);
      check_output("tbl_pkt_cnt", pkt_cnt, 1);
      check_output("tbl_rx_valid", rx_valid, deliver);
      if (deliver) check_output("tbl_rx_data", rx_data, vecs[i].pkt);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end

    // Stream of 20 with consumer stalled, then drain with the source still pushing
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    base  = pop_total;
    dbase = deliv_total;
    for (int i = 0; i < 20; i++) apply_stimulus(rand_pkt(1'b1));
    tick(80);
    check_output("stall_pops", pop_total - base, DEPTH);
    check_output("stall_pop_low", pop, 0);
    check_output("stall_pndng_held", pndng, 1);
    check_output("stall_src_left", src_q.size(), 20 - DEPTH);
    drain(300);
    check_output("stream_delivered", deliv_total - dbase, 20);
    check_output("stream_pkt_cnt_sat", pkt_cnt, CMAX);
    rx_ready = 1'b0;

    // Clear landing on the same edge as a capture
    apply_stimulus(rand_pkt(1'b1));
    wait_pop(20);
    check_output("sat_hold", pkt_cnt, CMAX);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    check_output("clr_wins_pkt", pkt_cnt, 0);
    check_output("clr_wins_valid", rx_valid, 1);

    // Reset during the POP cycle
    apply_stimulus(32'h0032_5555);
    wait_pop(20);
    rst_i = 1'b1;
    #1;
    check_output("rstpop_pop", pop, 0);
    check_output("rstpop_valid", rx_valid, 0);
    check_output("rstpop_pkt_cnt", pkt_cnt, 0);
    tick(2);
    check_output("rstpop_not_consumed", src_q.size(), 1);
    rst_i = 1'b0;
    tick(1);
    check_output("resume_pop", pop, 1);
    tick(1);
    check_output("resume_data", rx_data, 32'h0032_5555);
    check_output("resume_pkt_cnt", pkt_cnt, 1);
    drain(50);

    // Randomized traffic, gated source, random consumer and occasional clears
    for (int c = 0; c < 800; c++) begin
      mesh_en   = ($urandom_range(0, 3) != 0);
      rx_ready  = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0 && src_q.size() < 4) apply_stimulus(rand_pkt(1'b0));
      tick(1);
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
